// File: rtl/div_seq_r4.sv
// Sequential radix-4 restoring divider with valid/ready handshakes on both sides.
// Retires two quotient bits per cycle; supports unsigned and two's-complement operands.
module div_seq_r4 #(
  parameter int unsigned BWI1 = 8,
  parameter int unsigned BWI2 = 8,
  parameter int unsigned BWO1 = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            i_signed,
  input  logic [BWI1-1:0] i1,
  input  logic [BWI2-1:0] i2,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [BWO1-1:0] o1,
  output logic [BWI2-1:0] o2,
  output logic            o_dz
);

  localparam int unsigned NR = (BWI1 + 1) / 2;
  localparam int unsigned DW = 2 * NR;
  localparam int unsigned RW = BWI2 + 2;
  localparam int unsigned SW = BWI2 + 3;
  localparam int unsigned CW = $clog2(NR + 1);
  localparam int unsigned QX = (BWO1 > BWI1) ? BWO1 : BWI1;
  localparam int unsigned RX = (BWI2 > BWI1) ? BWI2 : BWI1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic            is_signed;
  logic            neg_q;
  logic            neg_r;
  logic            dz;
  logic [BWI1-1:0] a_raw;
  logic [DW-1:0]   dvd;
  logic [RW-1:0]   d1;
  logic [RW-1:0]   d2;
  logic [RW-1:0]   d3;
  logic [RW-1:0]   rem;
  logic [BWI1-1:0] quo;
  logic [CW-1:0]   cnt;

  logic [BWI1-1:0] a_mag;
  logic [BWI2-1:0] b_mag;
  logic [RW-1:0]   rem_sh;
  logic [RW-1:0]   rem_next;
  logic [SW-1:0]   t1;
  logic [SW-1:0]   t2;
  logic [SW-1:0]   t3;
  logic [1:0]      k;
  logic [BWI1-1:0] q_res;
  logic [BWI2-1:0] r_res;
  logic [QX-1:0]   q_x;
  logic [RX-1:0]   r_x;

  // Operand magnitudes at accept time
  always_comb begin
    a_mag = (i_signed && i1[BWI1-1]) ? -i1 : i1;
    b_mag = (i_signed && i2[BWI2-1]) ? -i2 : i2;
  end

  // One radix-4 round: shift in the next dividend pair, subtract the largest fitting multiple
  always_comb begin
    rem_sh   = RW'({rem, dvd[DW-1 -: 2]});
    t1       = {1'b0, rem_sh} - {1'b0, d1};
    t2       = {1'b0, rem_sh} - {1'b0, d2};
    t3       = {1'b0, rem_sh} - {1'b0, d3};
    k        = 2'd0;
    rem_next = rem_sh;
    if (!t3[SW-1]) begin
      k        = 2'd3;
      rem_next = t3[RW-1:0];
    end else if (!t2[SW-1]) begin
      k        = 2'd2;
      rem_next = t2[RW-1:0];
    end else if (!t1[SW-1]) begin
      k        = 2'd1;
      rem_next = t1[RW-1:0];
    end
  end

  // Final correction: divide-by-zero override, sign restore, quotient width fit
  always_comb begin
    q_res = quo;
    r_res = rem[BWI2-1:0];
    if (is_signed) r_x = RX'($signed(a_raw));
    else           r_x = RX'(a_raw);
    if (dz) begin
      q_res = '1;
      r_res = r_x[BWI2-1:0];
    end else if (is_signed) begin
      if (neg_q) q_res = -quo;
      if (neg_r) r_res = -rem[BWI2-1:0];
    end
    if (is_signed) q_x = QX'($signed(q_res));
    else           q_x = QX'(q_res);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o1        <= '0;
      o2        <= '0;
      o_dz      <= 1'b0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      a_raw     <= '0;
      dvd       <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid && i_ready) begin
            is_signed <= i_signed;
            neg_r     <= i_signed & i1[BWI1-1];
            neg_q     <= (i_signed & i1[BWI1-1]) ^ (i_signed & i2[BWI2-1]);
            dz        <= (i2 == '0);
            a_raw     <= i1;
            dvd       <= DW'(a_mag);
            d1        <= RW'(b_mag);
            d2        <= RW'({b_mag, 1'b0});
            d3        <= RW'(b_mag) + RW'({b_mag, 1'b0});
            rem       <= '0;
            quo       <= '0;
            cnt       <= CW'(NR);
            i_ready   <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          rem <= rem_next;
          quo <= (quo << 2) | BWI1'(k);
          dvd <= dvd << 2;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          o1      <= q_x[BWO1-1:0];
          o2      <= r_res;
          o_dz    <= dz;
          o_valid <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
